// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between an instruction-fetch
// port and a load/store port, with data priority, a fetch starvation guard and a transfer timeout.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_type,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_type,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,

    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr
);

    localparam int              TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [3:0]      STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [2:0]      TYPE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_busy;
    logic                w_timeout;
    logic                w_done;
    logic [TW-1:0]       r_tcnt;
    logic [3:0]          r_streak;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [2:0]          r_m_type;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_addr;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_timeout = w_busy && !m_ack && (r_tcnt == TO_LAST);
    assign w_done    = w_busy && (m_ack || w_timeout);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data wins unless fetch has already waited out the whole allowed streak.
                if (d_req && (!i_req || (r_streak != STREAK_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ST_BUSY_D;
                end else if (i_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_type  <= '0;
        end else if (w_grant_d) begin
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_type  <= d_type;
        end else if (w_grant_i) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= i_addr;
            r_m_wdata <= '0;
            r_m_type  <= TYPE_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (w_grant_d) begin
            if (!i_req) begin
                r_streak <= '0;
            end else if (r_streak != STREAK_MAX) begin
                r_streak <= r_streak + 4'd1;
            end
        end else if (w_grant_i) begin
            r_streak <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (w_grant_d || w_grant_i) begin
            r_tcnt <= '0;
        end else if (w_busy && !m_ack) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // A timeout beats a simultaneous clear; the address is only recaptured when err is not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) begin
                r_err_addr <= r_m_addr;
            end
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign m_req    = w_busy;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_type   = r_m_type;
    assign err      = r_err;
    assign err_addr = r_err_addr;

    assign i_ack   = (r_state == ST_BUSY_I) && w_done;
    assign d_ack   = (r_state == ST_BUSY_D) && w_done;
    assign i_rdata = ((r_state == ST_BUSY_I) && m_ack) ? m_rdata : '0;
    assign d_rdata = ((r_state == ST_BUSY_D) && m_ack) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives on the falling edge, checks #1 later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_type;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_type = 0; m_rdata = 0; m_ack = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL reset_m_we: got %b want 0", m_we); end
        total++; if ({i_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {i_ack, d_ack}); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if ({m_addr, m_wdata, m_type, err_addr} !== '0) begin
            bad++; $display("FAIL reset_payload: got %h %h %h %h want 0", m_addr, m_wdata, m_type, err_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_load();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h100; d_type = 3'b010;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL load_m_req_early: got %b want 0", m_req); end
        @(negedge clk); #1;
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL load_m_req: got %b want 1", m_req); end
        total++; if (m_addr !== 32'h100 || m_we !== 1'b0) begin
            bad++; $display("FAIL load_m_addr: got %h we=%b want 00000100 we=0", m_addr, m_we);
        end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            m_rdata = 32'h5555_5555;
            #1;
            total++; if (d_ack !== 1'b0 || d_rdata !== 32'h0) begin
                bad++; $display("FAIL load_wait_%0d: got ack=%b rdata=%h want ack=0 rdata=0", k, d_ack, d_rdata);
            end
        end
        @(negedge clk);
        m_ack = 1; m_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load_ack: got ack=%b rdata=%h want ack=1 rdata=deadbeef", d_ack, d_rdata);
        end
        total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL load_i_ack: got %b want 0", i_ack); end
        @(negedge clk);
        m_ack = 0; m_rdata = 0; d_req = 0;
        #1;
        total++; if (m_req !== 1'b0 || d_ack !== 1'b0) begin
            bad++; $display("FAIL load_release: got m_req=%b d_ack=%b want 0 0", m_req, d_ack);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234; d_type = 3'b001;
        @(negedge clk); #1;
        total++; if ({m_req, m_we, m_addr, m_wdata, m_type} !== {1'b1, 1'b1, 32'h20, 32'h1234, 3'b001}) begin
            bad++; $display("FAIL store_payload: got req=%b we=%b a=%h wd=%h t=%b want 1 1 20 1234 001",
                            m_req, m_we, m_addr, m_wdata, m_type);
        end
        m_ack = 1;
        #1;
        total++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
            bad++; $display("FAIL store_ack: got d_ack=%b i_ack=%b want 1 0", d_ack, i_ack);
        end
        @(negedge clk);
        m_ack = 0; d_req = 0; d_we = 0; d_wdata = 0; d_type = 0;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL store_release: got %b want 0", m_req); end
    endtask

    task automatic test_contention();
        bit exp_is_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [31:0] exp_addr;
        int w;
        @(negedge clk);
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80; d_type = 3'b010;
        #1;
        for (int k = 0; k < 10; k++) begin
            w = 0;
            while (m_req !== 1'b1 && w < 6) begin
                @(negedge clk); #1; w++;
            end
            total++; if (m_req !== 1'b1) begin
                bad++; $display("FAIL cont_timeout_%0d: got m_req=%b want 1", k, m_req);
                break;
            end
            exp_addr = exp_is_i[k] ? 32'h40 : 32'h80;
            m_ack = 1; m_rdata = mem_model(m_addr);
            #1;
            total++; if ({i_ack, d_ack} !== {exp_is_i[k], !exp_is_i[k]} || m_addr !== exp_addr) begin
                bad++; $display("FAIL cont_grant_%0d: got i_ack=%b d_ack=%b addr=%h want i_ack=%b addr=%h",
                                k, i_ack, d_ack, m_addr, exp_is_i[k], exp_addr);
            end
            total++; if ((exp_is_i[k] ? i_rdata : d_rdata) !== mem_model(exp_addr)) begin
                bad++; $display("FAIL cont_rdata_%0d: got i=%h d=%h want %h", k, i_rdata, d_rdata, mem_model(exp_addr));
            end
            @(negedge clk);
            m_ack = 0; m_rdata = 0;
            #1;
        end
        i_req = 0; d_req = 0;
        #1;
    endtask

    task automatic test_fetch_only();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        time t_prev = 0;
        int w;
        @(negedge clk);
        i_req = 1; i_addr = addrs[0];
        #1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (m_req !== 1'b1 && w < 4) begin
                @(negedge clk); #1; w++;
            end
            total++; if ({m_req, m_we, m_addr, m_wdata, m_type} !== {1'b1, 1'b0, addrs[k], 32'h0, 3'b010}) begin
                bad++; $display("FAIL fetch_payload_%0d: got req=%b we=%b a=%h wd=%h t=%b want 1 0 %h 0 010",
                                k, m_req, m_we, m_addr, m_wdata, m_type, addrs[k]);
            end
            m_ack = 1; m_rdata = mem_model(m_addr);
            #1;
            total++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== mem_model(addrs[k])) begin
                bad++; $display("FAIL fetch_ack_%0d: got i_ack=%b d_ack=%b rdata=%h want 1 0 %h",
                                k, i_ack, d_ack, i_rdata, mem_model(addrs[k]));
            end
            if (k > 0) begin
                total++; if ($time - t_prev != 20) begin
                    bad++; $display("FAIL fetch_period_%0d: got %0t want 20", k, $time - t_prev);
                end
            end
            t_prev = $time;
            @(negedge clk);
            m_ack = 0; m_rdata = 0;
            if (k < 2) i_addr = addrs[k+1]; else i_req = 0;
            #1;
            total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_gap_%0d: got %b want 0", k, m_req); end
        end
    endtask

    task automatic test_idle_ack();
        @(negedge clk);
        m_ack = 1; m_rdata = 32'hFFFF_0000;
        #1;
        total++; if ({i_ack, d_ack} !== 2'b00 || i_rdata !== 0 || d_rdata !== 0) begin
            bad++; $display("FAIL idle_ack: got i_ack=%b d_ack=%b i=%h d=%h want all 0", i_ack, d_ack, i_rdata, d_rdata);
        end
        @(negedge clk);
        m_ack = 0; m_rdata = 0;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL idle_m_req: got %b want 0", m_req); end
    endtask

    task automatic do_timeout(input logic [31:0] addr);
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = addr;
        repeat (8) @(negedge clk);
        @(negedge clk);
        d_req = 0;
        #1;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'hBAD0;
        @(negedge clk); #1;
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL to_m_req: got %b want 1", m_req); end
        for (int b = 1; b < 7; b++) begin
            @(negedge clk); #1;
            total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL to_early_ack_%0d: got %b want 0", b, d_ack); end
        end
        @(negedge clk);
        m_rdata = 32'h9999_9999;
        #1;
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'h0 || err !== 1'b0) begin
            bad++; $display("FAIL to_abort: got ack=%b rdata=%h err=%b want 1 0 0", d_ack, d_rdata, err);
        end
        @(negedge clk);
        d_req = 0; m_rdata = 0;
        #1;
        total++; if (err !== 1'b1 || err_addr !== 32'hBAD0 || m_req !== 1'b0) begin
            bad++; $display("FAIL to_err: got err=%b addr=%h m_req=%b want 1 0000bad0 0", err, err_addr, m_req);
        end
        do_timeout(32'hC000);
        total++; if (err !== 1'b1 || err_addr !== 32'hBAD0) begin
            bad++; $display("FAIL to_sticky: got err=%b addr=%h want 1 0000bad0", err, err_addr);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h300;
        @(negedge clk); #1;
        total++; if (m_req !== 1'b1 || err !== 1'b1) begin
            bad++; $display("FAIL rst_pre: got m_req=%b err=%b want 1 1", m_req, err);
        end
        #2;
        rst_n = 0; d_req = 0; i_req = 1; i_addr = 32'h44;
        #1;
        total++; if ({m_req, d_ack, err} !== 3'b000 || m_addr !== 32'h0) begin
            bad++; $display("FAIL rst_async: got m_req=%b d_ack=%b err=%b addr=%h want 0 0 0 0", m_req, d_ack, err, m_addr);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rst_idle: got %b want 0", m_req); end
        @(negedge clk); #1;
        total++; if (m_req !== 1'b1 || m_addr !== 32'h44) begin
            bad++; $display("FAIL rst_i_grant: got m_req=%b addr=%h want 1 00000044", m_req, m_addr);
        end
        m_ack = 1; m_rdata = mem_model(32'h44);
        #1;
        total++; if (i_ack !== 1'b1 || i_rdata !== mem_model(32'h44)) begin
            bad++; $display("FAIL rst_i_ack: got ack=%b rdata=%h want 1 %h", i_ack, i_rdata, mem_model(32'h44));
        end
        @(negedge clk);
        m_ack = 0; m_rdata = 0; i_req = 0;
        #1;
    endtask

    task automatic test_err_clr();
        do_timeout(32'hD000);
        total++; if (err !== 1'b1 || err_addr !== 32'hD000) begin
            bad++; $display("FAIL clr_capture: got err=%b addr=%h want 1 0000d000", err, err_addr);
        end
        @(negedge clk);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        #1;
        total++; if (err !== 1'b0 || err_addr !== 32'h0) begin
            bad++; $display("FAIL clr: got err=%b addr=%h want 0 0", err, err_addr);
        end
    endtask

    task automatic test_abort_cycle_ack();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h600;
        repeat (7) @(negedge clk);
        @(negedge clk);
        m_ack = 1; m_rdata = 32'h1357_9BDF;
        #1;
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'h1357_9BDF) begin
            bad++; $display("FAIL late_ack: got ack=%b rdata=%h want 1 13579bdf", d_ack, d_rdata);
        end
        @(negedge clk);
        m_ack = 0; m_rdata = 0; d_req = 0;
        #1;
        total++; if (err !== 1'b0 || m_req !== 1'b0) begin
            bad++; $display("FAIL late_ack_err: got err=%b m_req=%b want 0 0", err, m_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_contention();
        test_fetch_only();
        test_idle_ack();
        test_timeout();
        test_async_reset();
        test_err_clr();
        test_abort_cycle_ack();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between the riscv core's rom_addr/instr and ram_* interfaces and a unified SRAM/bus slave.
- Grants one requester at a time with data priority and a starvation guard for fetch.
- Aborts hung transfers with a timeout and records a sticky error.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_D_STREAK, 4, consecutive D grants allowed while I waits (legal 1..15)
TIMEOUT, 64, cycles a granted transfer may wait for m_ack before abort (legal 2..1023)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data, valid when i_ack
i_ack  out  1  fetch complete, one-cycle pulse
d_req  in  1  data request; held with payload stable until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_type  in  3  access size/sign (RW_type encoding), passed through
d_rdata  out  DATA_W  load data, valid when d_ack
d_ack  out  1  data complete, one-cycle pulse
m_req  out  1  memory request, held until m_ack or abort
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_type  out  3  memory access type
m_rdata  in  DATA_W  memory read data, valid with m_ack
m_ack  in  1  memory completion pulse
err  out  1  sticky timeout flag
err_addr  out  ADDR_W  m_addr of first timed-out transfer
err_clr  in  1  synchronous clear of err/err_addr

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; m_req, m_we, i_ack, d_ack, err = 0.
  - m_addr, m_wdata, m_type, err_addr = 0.
  - Streak and timeout counters = 0.
  - Reset mid-transfer abandons it silently; no ack is issued.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE transitions:
  - Only d_req -> BUSY_D.
  - Only i_req -> BUSY_I.
  - Both requesting -> BUSY_I if streak==MAX_D_STREAK, else BUSY_D.
  - Neither -> stay in IDLE.
- On a grant, the winner's payload is registered into m_* and m_req=1 on the next cycle.
  - I grants force m_we=0, m_wdata=0, m_type=3'b010 (word).
- Arbitration latency: 1 cycle from req sampled in IDLE to m_req high.
- BUSY_x, m_ack=1 in cycle N:
  - Owner's ack=1 in cycle N, combinational.
  - Owner's rdata = m_rdata in cycle N.
  - m_req=0 and FSM=IDLE from N+1.
- After an ack, the requester must drop req or present a new request by N+1. IDLE re-samples at N+1, so the minimum transfer period is 2 cycles for zero-wait memory. m_ack during N+1 is also ignored (see next item).
- m_ack while IDLE is ignored; no ack is generated.
- Non-owner ack is always 0. i_ack and d_ack are never high in the same cycle.
- rdata outputs are 0 when their ack is 0.
- Streak counter:
  - Increments on a D grant if i_req was high at grant, saturating at MAX_D_STREAK.
  - Clears on any I grant, or on a D grant with i_req low.
- Timeout counter:
  - Clears on entering BUSY_x and increments each BUSY cycle with m_ack=0.
  - When it reaches TIMEOUT-1 with m_ack still 0, that cycle aborts:
    - Owner ack=1 with rdata=0.
    - m_req drops next cycle; FSM goes to IDLE.
    - err set.
    - err_addr captured only if err was 0.
  - If m_ack arrives in the abort cycle, it is a normal completion: err is untouched and rdata = m_rdata.
- err_clr=1 clears err and err_addr next cycle. A timeout in the same cycle as err_clr wins: err=1 and err_addr is recaptured.
- m_* payload is stable for the whole BUSY period. Requester input changes during BUSY are ignored.

Test Plan:
- Single load: d_req, d_addr=0x100, m_ack 3 cycles after m_req with m_rdata=0xDEADBEEF -> m_req high 1 cycle after d_req; d_ack one cycle with d_rdata=0xDEADBEEF; m_req low next cycle.
- Store: d_we=1, d_addr=0x20, d_wdata=0x1234, d_type=3'b001, zero-wait m_ack -> m_we=1, m_wdata=0x1234, m_type=3'b001; d_ack in m_ack cycle; i_ack stays 0.
- Contention with MAX_D_STREAK=4: i_req and d_req both held, each D re-requested after ack -> grant order D,D,D,D,I,D,D,D,D,I; i_rdata matches the memory model.
- Fetch only, zero-wait memory, i_addr stepping 0,4,8 -> one i_ack every 2 cycles with matching data; m_we=0 throughout.
- Timeout with TIMEOUT=8: d_req to 0xBAD0, m_ack never asserted -> d_ack with d_rdata=0 at cycle 7 of BUSY; err=1, err_addr=0xBAD0. A second timeout to 0xC000 leaves err_addr=0xBAD0. err_clr -> err=0, err_addr=0.
- Async reset mid-BUSY_D (rst_n low between clock edges) -> m_req, d_ack, err go 0 immediately. After release with i_req held, the first grant is I within 1 cycle.
